riscv_lsu: RTL and testbench
============================

# riscv_lsu

Parametrised load/store unit with on-block data memory for the RISC-V core. Generalises the core's single-cycle data-memory path into a handshaked, multi-cycle unit: configurable depth and wait states, RV32I sub-word accesses (byte/half/word, signed/unsigned), fault reporting, and a commit-trace port matching the core's `wr/rd/addr/wr_data/rd_data` outputs. Sits between the Datapath's MEM stage and the core top; `busy` drives the pipeline stall.

## Interface
- `DATA_W`, 32, data width. Only 32 is supported; lane logic assumes 4 bytes.
- `DEPTH`, 128, memory depth in words, power of two.
- `ADDR_W`, 9, byte-address width. Requires `2**ADDR_W >= 4*DEPTH`.
- `WAIT_STATES`, 1, extra cycles between accept and response, 0..15.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in DATA_W: store data, right-aligned.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out DATA_W: extended load result; 0 for stores and faults.
- `rsp_fault` out 1: access faulted, valid with `rsp_valid`.
- `busy` out 1: request in flight; equals `!req_ready`.
- `wr`, `rd` out 1: trace pulses for a committed store or load.
- `addr` out ADDR_W: trace byte address.
- `wr_data` out DATA_W: trace of the full merged word written.
- `rd_data` out DATA_W: trace of the extended load value.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - `req_ready = (state == IDLE)`.
  - Accept happens when `req_valid && req_ready`. All request fields are latched at accept.
  - IDLE goes to WAIT on accept, or straight to RESP if `WAIT_STATES == 0`.
  - WAIT counts `WAIT_STATES` cycles, then goes to RESP.
  - RESP lasts one cycle, then returns to IDLE. A new request cannot be accepted in RESP.
- Word index = `addr[ADDR_W-1:2]`. An index `>= DEPTH` is an out-of-range fault.
- funct3 values that are not legal are a fault:
  - loads: 011, 110, 111;
  - stores: any value >= 011.
- Store commit:
  - SB writes lane `addr[1:0]`.
  - SH writes lanes `{addr[1],0}` and `{addr[1],1}`.
  - SW writes all 4 lanes.
  - Other lanes are preserved.
  - The write happens on the clock edge that enters RESP. A faulted store writes nothing.
- Load result:
  - The selected lane(s) are shifted to bit 0.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Trace outputs are registered and aligned with `rsp_valid`.
  - `wr`/`rd` pulse only for non-faulted accesses.
  - `addr`, `wr_data` and `rd_data` hold their last values otherwise.
- Memory array is not reset; contents are undefined until written.

## Timing
- Latency from the accept edge to `rsp_valid` high is `WAIT_STATES+1` cycles.
- Throughput is one request per `WAIT_STATES+2` cycles.
- Reset values (after the first edge with `reset == 0`):
  - state = IDLE, so `req_ready` = 1 and `busy` = 0;
  - `rsp_valid`, `rsp_fault`, `wr`, `rd` = 0;
  - `rsp_rdata`, `addr`, `wr_data`, `rd_data` = 0.
- Reset mid-operation: the in-flight request is abandoned. No response is produced. A store is lost unless its commit edge already occurred.
- `req_valid` while busy is ignored. The requester must hold it until accepted.
- A fault response has the same latency as a normal response.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a misaligned access raises `rsp_fault`, with no write and no trace pulse.
  - halfword misaligned: `addr[0]` set;
  - word misaligned: `addr[1:0]` not 00.
- Undefined: misaligned accesses are silently aligned by ignoring the low address bits, and never fault on alignment. The trace `addr` shows the aligned address.

## Structure
- Shared package `riscv_lsu_pkg` holds:
  - the `lsu_state_e` enum (IDLE/WAIT/RESP);
  - funct3 constants `F3_B/F3_H/F3_W/F3_BU/F3_HU`;
  - lane-select and extend functions.
- One sub-module, `lsu_lane_align`: a combinational block producing the byte-enable mask, the shifted store word, and the extended load value.
- The memory array is inline for BRAM inference.

## Test plan
- Reset, then SW of 0xDEADBEEF to addr 0x010, then LW from 0x010 (`WAIT_STATES=1`):
  - `rsp_valid` appears 2 cycles after each accept;
  - `rsp_rdata` = 0xDEADBEEF;
  - `wr` then `rd` pulse, with trace `addr` = 0x010.
- SB 0x80 to 0x011, then:
  - LB at 0x011 → 0xFFFFFF80;
  - LBU at 0x011 → 0x00000080;
  - LW at 0x010 → 0xDEAD80EF.
- SH 0x8001 to 0x012, then:
  - LH at 0x012 → 0xFFFF8001;
  - LHU at 0x012 → 0x00008001.
- LW at word index DEPTH (byte addr 0x200 needs `ADDR_W=10`), or load funct3=011 → `rsp_fault`=1, `rsp_rdata`=0, no `rd`. A store of this kind leaves memory unchanged.
- LH at 0x013:
  - with `LSU_MISALIGN_TRAP_EN` → fault;
  - without it → value read from 0x012.
- Reset asserted in the WAIT state of an SW to 0x020 → no `rsp_valid`, `req_ready`=1 on the next cycle, and a later LW from 0x020 returns the prior contents.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: FSM state type, RV32I funct3 codes and lane helpers shared by riscv_lsu.
package riscv_lsu_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} lsu_state_e;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
        return f3[1:0] == 2'b00 ? 4'b0001 << off : f3[1:0] == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        return f3 == F3_B  ? {{24{s[7]}}, s[7:0]} :
               f3 == F3_H  ? {{16{s[15]}}, s[15:0]} :
               f3 == F3_BU ? {24'b0, s[7:0]} :
               f3 == F3_HU ? {16'b0, s[15:0]} : s;
    endfunction
endpackage

// File: rtl/riscv_lsu_lane_align.sv
// lsu_lane_align: byte-enable mask, lane-shifted store word and extended load value.
module lsu_lane_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);
    always_comb begin
        be    = lane_mask(funct3, off);
        wword = wdata << {off, 3'b000};
        rdata = extend(rword, funct3, off);
    end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: handshaked multi-cycle load/store unit with inline data memory and commit trace.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of silently aligning them.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 128,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic              busy,
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    localparam int IW = $clog2(DEPTH);
    lsu_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic we_q, we_d, rsp_valid_q, rsp_valid_d, rsp_fault_q, rsp_fault_d, wr_q, wr_d, rd_q, rd_d;
    logic [2:0] f3_q, f3_d;
    logic [ADDR_W-1:0] ra_q, ra_d, addr_q, addr_d;
    logic [DATA_W-1:0] wd_q, wd_d, rsp_rdata_q, rsp_rdata_d, wr_data_q, wr_data_d, rd_data_q, rd_data_d;
    logic idle, go, we, mis, fault;
    logic [2:0] f3;
    logic [3:0] be;
    logic [ADDR_W-1:0] ra, al;
    logic [DATA_W-1:0] wd, old, mask, merged, wword, rdata;
    logic [DATA_W-1:0] mem [DEPTH];

    lsu_lane_align u_align (
        .funct3(f3),
        .off   (al[1:0]),
        .wdata (wd),
        .rword (old),
        .be    (be),
        .wword (wword),
        .rdata (rdata)
    );

    // In IDLE the live request fields are used so a zero-wait access can commit on its accept edge.
    always_comb begin
        idle   = state_q == IDLE;
        we     = idle ? req_we : we_q;
        f3     = idle ? req_funct3 : f3_q;
        ra     = idle ? req_addr : ra_q;
        wd     = idle ? req_wdata : wd_q;
        al     = {ra[ADDR_W-1:2], f3[1:0] == 2'b10 ? 2'b00 : f3[1:0] == 2'b01 ? {ra[1], 1'b0} : ra[1:0]};
`ifdef LSU_MISALIGN_TRAP_EN
        mis    = al != ra;
`else
        mis    = 1'b0;
`endif
        fault  = mis || 32'(ra[ADDR_W-1:2]) >= DEPTH ||
                 (we ? f3 > F3_W : (f3 == 3'b011 || f3[2:1] == 2'b11));
        old    = mem[ra[IW+1:2]];
        mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        merged = (wword & mask) | (old & ~mask);
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = WAIT_STATES == 0 ? RESP : WAIT;
                cnt_d   = 4'(WAIT_STATES - 1);
            end
            WAIT: begin
                state_d = cnt_q == 4'd0 ? RESP : WAIT;
                cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        go          = state_d == RESP && state_q != RESP;
        we_d        = we;
        f3_d        = f3;
        ra_d        = ra;
        wd_d        = wd;
        rsp_valid_d = go;
        rsp_fault_d = go && fault;
        rsp_rdata_d = go ? (we || fault ? '0 : rdata) : rsp_rdata_q;
        wr_d        = go && we && !fault;
        rd_d        = go && !we && !fault;
        addr_d      = wr_d || rd_d ? al : addr_q;
        wr_data_d   = wr_d ? merged : wr_data_q;
        rd_data_d   = rd_d ? rdata : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && wr_d) mem[ra[IW+1:2]] <= merged;
        we_q <= we_d;
        f3_q <= f3_d;
        ra_q <= ra_d;
        wd_q <= wd_d;
    end

    assign req_ready = idle;
    assign busy      = !idle;
    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_rdata = rsp_rdata_q;
    assign wr        = wr_q;
    assign rd        = rd_q;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign rd_data   = rd_data_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed plus randomized checks of riscv_lsu against a byte-array reference model.
module tb_riscv_lsu;
    localparam int WS = 1, DEPTH = 128, AW = 10;
    logic clk = 0, reset = 0, req_valid = 0, req_we = 0;
    logic [2:0] req_funct3 = 0;
    logic [AW-1:0] req_addr = 0;
    logic [31:0] req_wdata = 0;
    logic req_ready, rsp_valid, rsp_fault, busy, wr, rd;
    logic [31:0] rsp_rdata, wr_data, rd_data;
    logic [AW-1:0] addr;
    int checks = 0, errors = 0;
    logic [7:0] mm [0:4*DEPTH-1];
    logic [AW-1:0] t_addr = 0;
    logic [31:0] t_wd = 0, t_rd = 0, got;
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    riscv_lsu #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .busy(busy), .wr(wr), .rd(rd), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic we, input logic [2:0] f3, input logic [AW-1:0] a,
                       input logic [31:0] wd, output logic [31:0] res);
        int size, n, base;
        logic fault;
        logic [31:0] v;
        size  = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        fault = (we ? f3 > 3'd2 : (f3 == 3'd3 || f3 > 3'd5)) || (int'(a) >> 2) >= DEPTH;
`ifdef LSU_MISALIGN_TRAP_EN
        fault = fault || (int'(a) % size) != 0;
`endif
        base = int'(a) & ~(size - 1);
        v = 0;
        if (!fault && we) begin
            for (int i = 0; i < size; i++) mm[base + i] = wd[8*i +: 8];
            for (int i = 0; i < 4; i++) v[8*i +: 8] = mm[(base & ~3) + i];
            t_addr = AW'(base);
            t_wd = v;
        end
        if (!fault && !we) begin
            for (int i = 0; i < size; i++) v[8*i +: 8] = mm[base + i];
            if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
            t_addr = AW'(base);
            t_rd = v;
        end
        @(negedge clk);
        chk("ready_before", 32'(req_ready), 1);
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 0;
        n = 1;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency", 32'(n), 32'(WS + 1));
        chk("busy_rsp", 32'(busy), 1);
        chk("fault", 32'(rsp_fault), 32'(fault));
        chk("rdata", rsp_rdata, (fault || we) ? 32'd0 : v);
        chk("wr", 32'(wr), 32'(we && !fault));
        chk("rd", 32'(rd), 32'(!we && !fault));
        chk("tr_addr", 32'(addr), 32'(t_addr));
        chk("tr_wdata", wr_data, t_wd);
        chk("tr_rdata", rd_data, t_rd);
        res = rsp_rdata;
        @(posedge clk);
        #1;
        chk("rsp_pulse", 32'(rsp_valid), 0);
        chk("ready_after", 32'(req_ready), 1);
    endtask

    initial begin
        logic we;
        logic [2:0] f3;
        logic [AW-1:0] a;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_fault", 32'(rsp_fault), 0);
        chk("rst_wr_rd", {30'd0, wr, rd}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_wdata", wr_data, 0);
        chk("rst_rd_data", rd_data, 0);
        reset = 1;
        for (int w = 0; w < DEPTH; w++) txn(1, 3'd2, AW'(4 * w), $urandom, got);
        txn(1, 3'd2, 10'h010, 32'hDEADBEEF, got);
        txn(0, 3'd2, 10'h010, 0, got);
        chk("lw_deadbeef", got, 32'hDEADBEEF);
        txn(1, 3'd0, 10'h011, 32'h80, got);
        txn(0, 3'd0, 10'h011, 0, got);
        chk("lb_80", got, 32'hFFFFFF80);
        txn(0, 3'd4, 10'h011, 0, got);
        chk("lbu_80", got, 32'h00000080);
        txn(0, 3'd2, 10'h010, 0, got);
        chk("lw_merged_b", got, 32'hDEAD80EF);
        txn(1, 3'd1, 10'h012, 32'h8001, got);
        txn(0, 3'd1, 10'h012, 0, got);
        chk("lh_8001", got, 32'hFFFF8001);
        txn(0, 3'd5, 10'h012, 0, got);
        chk("lhu_8001", got, 32'h00008001);
        txn(0, 3'd2, 10'h200, 0, got);
        txn(0, 3'd3, 10'h010, 0, got);
        txn(1, 3'd3, 10'h010, 32'h12345678, got);
        txn(1, 3'd2, 10'h210, 32'h12345678, got);
        txn(0, 3'd2, 10'h010, 0, got);
        chk("store_fault_nowrite", got, 32'h800180EF);
        txn(0, 3'd1, 10'h013, 0, got);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lh_mis_fault", 32'(rsp_fault), 1);
`else
        chk("lh_mis_aligned", got, 32'hFFFF8001);
`endif
        @(negedge clk);
        req_valid = 1; req_we = 1; req_funct3 = 3'd2; req_addr = 10'h020; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 0;
        chk("wait_busy", 32'(busy), 1);
        reset = 0;
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(rsp_valid), 0);
        chk("midrst_ready", 32'(req_ready), 1);
        chk("midrst_wr", 32'(wr), 0);
        reset = 1;
        t_addr = 0; t_wd = 0; t_rd = 0;
        txn(0, 3'd2, 10'h020, 0, got);
        chk("midrst_lost", got, {mm[35], mm[34], mm[33], mm[32]});
        for (int k = 0; k < 200; k++) begin
            we = 1'($urandom_range(0, 1));
            f3 = $urandom_range(0, 7) == 0 ? 3'($urandom_range(0, 7)) :
                 we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            a = $urandom_range(0, 9) == 0 ? AW'($urandom_range(512, 1023)) : AW'($urandom_range(0, 511));
            txn(we, f3, a, $urandom, got);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
